calc_n_tagged: RTL and testbench
================================

Name: calc_n_tagged

Overview:
- Parametrised successor to the four-port calculator: NUM_PORTS independent request channels, configurable data width, per-port request queues and a tag on every request.
- Each port captures the two-cycle request (cmd + operand1, then operand2) and queues it.
- A round-robin arbiter issues one request per cycle to a shared fixed-latency execution pipe (add, sub, shift left, shift right).
- Each result returns on the originating port with its tag and a 2-bit response code.

Parameters:
- NUM_PORTS, 4, number of request/response channels (2..8).
- DATA_W, 32, operand and result width.
- TAG_W, 2, request tag width.
- QDEPTH, 4, request queue entries per port (power of 2, >=2).

Ports:
- c_clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_cmd_in  in  4*NUM_PORTS  per-port command; port p occupies slice p.
- req_data_in  in  DATA_W*NUM_PORTS  per-port operand.
- req_tag_in  in  TAG_W*NUM_PORTS  per-port tag, sampled in the cmd cycle.
- req_ready  out  NUM_PORTS  per-port: a command is accepted this cycle only if high.
- out_resp  out  2*NUM_PORTS  per-port response: 0 none, 1 success, 2 error, 3 unused.
- out_data  out  DATA_W*NUM_PORTS  per-port result; valid when out_resp != 0.
- out_tag  out  TAG_W*NUM_PORTS  per-port tag of the returned result.

Behaviour:
- Reset
  - While reset is high at a clock edge: all queues emptied, capture FSMs to IDLE, pipe valid bits cleared, arbiter pointer set to NUM_PORTS-1.
  - req_ready, out_resp, out_data and out_tag are all 0.
  - req_ready goes high in the first cycle after reset deasserts.
  - Requests in flight at reset are dropped with no response.
- Capture FSM, one per port
  - IDLE: req_cmd_in != 0 and req_ready = 1 latches cmd, operand1 and tag, then goes to WAIT_OP2. cmd != 0 with req_ready = 0 is ignored, with no response.
  - WAIT_OP2: req_data_in is taken as operand2 unconditionally, even if cmd != 0 (that cmd is ignored). The entry {cmd, op1, op2, tag} is written to the port queue on that edge, then the FSM returns to IDLE.
- req_ready[p]
  - Equals (occupancy[p] + (state == WAIT_OP2)) < QDEPTH.
  - It is registered, so it always reflects room for one more full request.
  - A queue write is never lost and never overflows.
- Queue
  - Per-port FIFO. A simultaneous write and pop in the same cycle is legal at any occupancy, including full.
  - Pointers wrap modulo QDEPTH. Per-port order is preserved end to end.
- Arbiter
  - Each cycle it grants the first non-empty queue searching upward from pointer+1, modulo NUM_PORTS.
  - The granted head is popped on that edge and the pointer becomes the granted port. No grant leaves the pointer unchanged.
  - At most one issue per cycle.
- Execute pipe
  - Fixed latency of 2: an issue in cycle I produces its response visible in cycle I+2, for exactly one cycle, on the granted port only. All other ports show out_resp = 0.
  - Unloaded end-to-end: cmd in cycle T gives a response in cycle T+4.
  - cmd 1 add (unsigned): a carry out of DATA_W bits gives resp 2 with data 0; otherwise resp 1 with the sum.
  - cmd 2 sub (unsigned): op2 > op1 gives resp 2 with data 0; otherwise resp 1 with op1-op2.
  - cmd 5 shift left: op1 << op2[clog2(DATA_W)-1:0]; vacated bits are 0; resp 1 always.
  - cmd 6 shift right: op1 >> op2[clog2(DATA_W)-1:0]; vacated bits are 0; resp 1 always.
  - cmd 3, 4, 7..15: queued and issued normally, then return resp 2 with data 0. The tag is returned as captured.
- Outputs
  - out_data and out_tag are 0 whenever out_resp = 0.

Test Plan:
- Reset 4 cycles, then idle: all outputs 0 during reset; req_ready = all 1s in the first post-reset cycle.
- Port 0, cmd 1, tag 2, op1 0x1, op2 0x1FFFFFFF issued in cycle T: out_resp[0] = 1, data 0x20000000, tag 2 in cycle T+4 only; other ports show resp 0.
- Port 1 add 0xFFFFFFFF + 0x1 -> resp 2, data 0. Port 1 sub 0x1 - 0xF -> resp 2, data 0. Port 1 cmd 4 -> resp 2, data 0.
- Shift sweep on port 2: cmd 6 with op1 0x80000000 and op2 = k for k = 0..31 -> data 0x80000000 >> k. cmd 5 with op1 0x1 and op2 = 33 -> data 0x2 (shift of 1).
- All 4 ports issue an add in the same cycle: responses arrive on 4 consecutive cycles in order port 0, 1, 2, 3, with correct tags.
- Back-pressure and reset:
  - Flood port 3 with 6 back-to-back requests while ports 0-2 are loaded: req_ready[3] drops once 4 are pending.
  - Commands presented while not ready get no response; all accepted ones return in order.
  - Assert reset with 3 requests queued: no responses afterwards, and occupancy is 0.

Source files
------------

// File: rtl/calc_n_tagged.sv
// Multi-port tagged calculator: per-port two-cycle request capture into a FIFO,
// round-robin issue into a shared 2-stage execute pipe, results routed back by port.

module calc_n_tagged_port #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2,
  parameter int QDEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              pop_i,
  output logic              ready_o,
  output logic              nempty_o,
  output logic [3:0]        hd_cmd_o,
  output logic [DATA_W-1:0] hd_op1_o,
  output logic [DATA_W-1:0] hd_op2_o,
  output logic [TAG_W-1:0]  hd_tag_o
);
  localparam int AW = $clog2(QDEPTH);

  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [TAG_W-1:0]  tag;
  } req_t;

  typedef enum logic {S_IDLE, S_WAIT_OP2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  req_t              mem_q [QDEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       occ_q, occ_d;
  logic [AW+1:0]     need_d;
  logic              ready_q, ready_d, wr;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    tag_d   = tag_q;
    wr      = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_i != 4'd0 && ready_q) begin
        state_d = S_WAIT_OP2;
        cmd_d   = cmd_i;
        op1_d   = data_i;
        tag_d   = tag_i;
      end
      S_WAIT_OP2: begin
        wr      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    occ_d   = occ_q + (AW+1)'(wr) - (AW+1)'(pop_i);
    // A half-captured request already owns a slot, so it counts against room.
    need_d  = (AW+2)'(occ_d) + (AW+2)'(state_d == S_WAIT_OP2);
    ready_d = need_d < (AW+2)'(QDEPTH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      tag_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      tag_q   <= tag_d;
      occ_q   <= occ_d;
      ready_q <= ready_d;
      if (wr)    wptr_q <= wptr_q + 1'b1;
      if (pop_i) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= {cmd_q, op1_q, data_i, tag_q};
  end

  assign ready_o  = ready_q & ~rst_i;
  assign nempty_o = (occ_q != '0);
  assign hd_cmd_o = mem_q[rptr_q].cmd;
  assign hd_op1_o = mem_q[rptr_q].op1;
  assign hd_op2_o = mem_q[rptr_q].op2;
  assign hd_tag_o = mem_q[rptr_q].tag;
endmodule

module calc_n_tagged #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2,
  parameter int QDEPTH    = 4
) (
  input  logic                               c_clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0][3:0]          req_cmd_in,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   req_data_in,
  input  logic [NUM_PORTS-1:0][TAG_W-1:0]    req_tag_in,
  output logic [NUM_PORTS-1:0]               req_ready,
  output logic [NUM_PORTS-1:0][1:0]          out_resp,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]   out_data,
  output logic [NUM_PORTS-1:0][TAG_W-1:0]    out_tag
);
  localparam int PW     = $clog2(NUM_PORTS);
  localparam int SHW    = $clog2(DATA_W);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [PW-1:0]     port;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [TAG_W-1:0]  tag;
  } iss_t;

  typedef struct packed {
    logic [PW-1:0]     port;
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } rsp_t;

  logic [NUM_PORTS-1:0]             nempty, pop;
  logic [NUM_PORTS-1:0][3:0]        hd_cmd;
  logic [NUM_PORTS-1:0][DATA_W-1:0] hd_op1, hd_op2;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  hd_tag;

  logic [PW-1:0]     ptr_q, gnt_idx, cand;
  logic              gnt_vld;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  iss_t              iss_d, s1_q;
  rsp_t              ex_d, s2_q;
  logic [DATA_W:0]   sum;
  logic [SHW-1:0]    sh;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc_n_tagged_port #(.DATA_W(DATA_W), .TAG_W(TAG_W), .QDEPTH(QDEPTH)) u_port (
      .clk_i    (c_clk),
      .rst_i    (reset),
      .cmd_i    (req_cmd_in[p]),
      .data_i   (req_data_in[p]),
      .tag_i    (req_tag_in[p]),
      .pop_i    (pop[p]),
      .ready_o  (req_ready[p]),
      .nempty_o (nempty[p]),
      .hd_cmd_o (hd_cmd[p]),
      .hd_op1_o (hd_op1[p]),
      .hd_op2_o (hd_op2[p]),
      .hd_tag_o (hd_tag[p])
    );
    assign pop[p]      = gnt_vld && (gnt_idx == PW'(p));
    assign out_resp[p] = (vld_pipe[STAGES] && s2_q.port == PW'(p)) ? s2_q.resp : 2'd0;
    assign out_data[p] = (vld_pipe[STAGES] && s2_q.port == PW'(p)) ? s2_q.data : '0;
    assign out_tag[p]  = (vld_pipe[STAGES] && s2_q.port == PW'(p)) ? s2_q.tag  : '0;
  end

  // Search starts just past the last winner, so the previous grantee goes last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_PORTS);
      if (!gnt_vld && nempty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    iss_d.port = gnt_idx;
    iss_d.cmd  = hd_cmd[gnt_idx];
    iss_d.op1  = hd_op1[gnt_idx];
    iss_d.op2  = hd_op2[gnt_idx];
    iss_d.tag  = hd_tag[gnt_idx];
  end

  always_comb begin
    sum       = {1'b0, s1_q.op1} + {1'b0, s1_q.op2};
    sh        = s1_q.op2[SHW-1:0];
    ex_d.port = s1_q.port;
    ex_d.tag  = s1_q.tag;
    ex_d.resp = 2'd2;
    ex_d.data = '0;
    case (s1_q.cmd)
      4'd1: if (!sum[DATA_W]) begin
        ex_d.resp = 2'd1;
        ex_d.data = sum[DATA_W-1:0];
      end
      4'd2: if (s1_q.op2 <= s1_q.op1) begin
        ex_d.resp = 2'd1;
        ex_d.data = s1_q.op1 - s1_q.op2;
      end
      4'd5: begin
        ex_d.resp = 2'd1;
        ex_d.data = s1_q.op1 << sh;
      end
      4'd6: begin
        ex_d.resp = 2'd1;
        ex_d.data = s1_q.op1 >> sh;
      end
      default: ;
    endcase
  end

  assign vld_pipe = {vld_q, gnt_vld};

  always_ff @(posedge c_clk) begin
    if (reset) begin
      vld_q <= '0;
      ptr_q <= PW'(NUM_PORTS - 1);
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (gnt_vld) ptr_q <= gnt_idx;
    end
  end

  // Payload registers need no reset; every consumer is qualified by vld_pipe.
  always_ff @(posedge c_clk) begin
    if (vld_pipe[0]) s1_q <= iss_d;
    if (vld_pipe[1]) s2_q <= ex_d;
  end
endmodule

// File: tb/tb_calc_n_tagged.sv
// Directed bench for calc_n_tagged: per-port scoreboard queues filled at
// request time and drained by a negedge monitor as responses appear.
module tb_calc_n_tagged;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;

  logic                    c_clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NP-1:0][3:0]      req_cmd_in;
  logic [NP-1:0][DW-1:0]   req_data_in;
  logic [NP-1:0][TW-1:0]   req_tag_in;
  logic [NP-1:0]           req_ready;
  logic [NP-1:0][1:0]      out_resp;
  logic [NP-1:0][DW-1:0]   out_data;
  logic [NP-1:0][TW-1:0]   out_tag;

  calc_n_tagged #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .QDEPTH(4)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .req_tag_in  (req_tag_in),
    .req_ready   (req_ready),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_tag     (out_tag)
  );

  always #5 c_clk = ~c_clk;

  int cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    int          cyc;
  } exp_t;

  exp_t sbq [NP][$];
  int npass = 0, ntot = 0, nresp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (c)
      4'd1:    return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      4'd2:    return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5:    return {2'd1, a << b[4:0]};
      4'd6:    return {2'd1, a >> b[4:0]};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  task automatic push(input int p, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] t, input int when);
    exp_t e;
    {e.resp, e.data} = model(c, a, b);
    e.tag = t;
    e.cyc = when;
    sbq[p].push_back(e);
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (sbq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Response monitor: every nonzero response must match the head of its port queue.
  always @(negedge c_clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      for (int p = 0; p < NP; p++) begin
        if (out_resp[p] != 2'd0) begin
          nresp++;
          if (sbq[p].size() == 0) begin
            chk($sformatf("unexpected_resp_p%0d", p), out_resp[p], 0);
          end else begin
            e = sbq[p].pop_front();
            chk($sformatf("resp_p%0d", p), out_resp[p], e.resp);
            chk($sformatf("data_p%0d", p), out_data[p], e.data);
            chk($sformatf("tag_p%0d", p), out_tag[p], e.tag);
            if (e.cyc >= 0) chk($sformatf("cycle_p%0d", p), cyc, e.cyc);
          end
        end else begin
          chk($sformatf("idle_zero_p%0d", p), {out_data[p], out_tag[p]}, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic clear_in();
    req_cmd_in  = '0;
    req_data_in = '0;
    req_tag_in  = '0;
  endtask

  task automatic send(input int p, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] t);
    chk($sformatf("ready_p%0d", p), req_ready[p], 1);
    req_cmd_in[p]  = c;
    req_data_in[p] = a;
    req_tag_in[p]  = t;
    push(p, c, a, b, t, cyc + 4);
    tick();
    req_cmd_in[p]  = 4'd0;
    req_data_in[p] = b;
    req_tag_in[p]  = '0;
    tick();
    req_data_in[p] = '0;
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int n = 0;
    while (!all_empty() && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, all_empty(), 1);
    repeat (3) tick();
  endtask

  // All ports request back-to-back; refused commands are not scoreboarded.
  task automatic flood(input int nreq, input int maxc, output logic [NP-1:0] saw_low);
    int          left [NP];
    bit          ph   [NP];
    logic [31:0] op2s [NP];
    logic [3:0]  cl   [5] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd4};
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [1:0]  t;
    bit          busy;
    int          n = 0;
    saw_low = '0;
    for (int p = 0; p < NP; p++) begin
      left[p] = nreq;
      ph[p]   = 1'b0;
    end
    busy = 1'b1;
    while (busy && n < maxc) begin
      for (int p = 0; p < NP; p++) begin
        if (ph[p]) begin
          req_cmd_in[p]  = 4'h7;
          req_data_in[p] = op2s[p];
          req_tag_in[p]  = '0;
          ph[p] = 1'b0;
        end else if (left[p] > 0) begin
          c = cl[$urandom_range(0, 4)];
          a = $urandom;
          b = (c == 4'd5 || c == 4'd6) ? 32'($urandom_range(0, 40)) : $urandom;
          t = 2'($urandom_range(0, 3));
          req_cmd_in[p]  = c;
          req_data_in[p] = a;
          req_tag_in[p]  = t;
          if (req_ready[p]) begin
            push(p, c, a, b, t, -1);
            op2s[p] = b;
            ph[p]   = 1'b1;
            left[p]--;
          end else begin
            saw_low[p] = 1'b1;
          end
        end else begin
          req_cmd_in[p]  = 4'd0;
          req_data_in[p] = '0;
        end
      end
      tick();
      n++;
      busy = 1'b0;
      for (int p = 0; p < NP; p++) if (left[p] > 0 || ph[p]) busy = 1'b1;
    end
    clear_in();
  endtask

  initial begin
    logic [NP-1:0] lows;
    int            t0, r0;
    clear_in();
    reset = 1'b1;
    @(posedge c_clk);
    @(negedge c_clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_resp", out_resp, 0);
    chk("rst_data", out_data, 0);
    chk("rst_tag", out_tag, 0);
    repeat (3) @(posedge c_clk);
    #1 reset = 1'b0;
    #1 chk("post_rst_ready", req_ready, 4'hF);
    tick();
    tick();

    send(0, 4'd1, 32'h1, 32'h1FFF_FFFF, 2'd2);
    wait_drain("drain_basic", 20);

    send(1, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd1);
    send(1, 4'd2, 32'h1, 32'hF, 2'd3);
    send(1, 4'd4, 32'h55, 32'h66, 2'd0);
    wait_drain("drain_errors", 20);

    for (int k = 0; k < 32; k++) send(2, 4'd6, 32'h8000_0000, 32'(k), 2'(k));
    send(2, 4'd5, 32'h1, 32'd33, 2'd1);
    wait_drain("drain_shift", 20);

    // Leave the arbiter pointer on port 3 so the next round starts at port 0.
    send(3, 4'd2, 32'd5, 32'd3, 2'd1);
    wait_drain("drain_p3", 20);

    t0 = cyc;
    for (int p = 0; p < NP; p++) begin
      req_cmd_in[p]  = 4'd1;
      req_data_in[p] = 32'h100 * p + 1;
      req_tag_in[p]  = 2'(p ^ 1);
      push(p, 4'd1, 32'h100 * p + 1, 32'h10 + p, 2'(p ^ 1), t0 + 4 + p);
    end
    tick();
    for (int p = 0; p < NP; p++) begin
      req_cmd_in[p]  = 4'd0;
      req_data_in[p] = 32'h10 + p;
      req_tag_in[p]  = '0;
    end
    tick();
    clear_in();
    wait_drain("drain_all4", 20);

    flood(12, 400, lows);
    chk("ready3_dropped", lows[3], 1);
    wait_drain("drain_flood", 300);
    chk("ready_recovered", req_ready, 4'hF);

    flood(12, 20, lows);
    reset = 1'b1;
    for (int p = 0; p < NP; p++) sbq[p].delete();
    tick();
    tick();
    reset = 1'b0;
    #1 chk("ready_after_rst2", req_ready, 4'hF);
    r0 = nresp;
    repeat (10) tick();
    chk("no_resp_after_rst", nresp - r0, 0);
    send(0, 4'd1, 32'h10, 32'h20, 2'd3);
    wait_drain("drain_post_rst", 20);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
